// File: rtl/shift_sequencer.sv
// shift_sequencer: turns one shift request into a run of single-step Mic-1 shifter
// operations (SRA by 1 or SLL by 8). Optional macro SHIFT_SEQ_EARLY_EN ends SRA early.
module shift_sequencer #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op,
    input  logic [AMT_W-1:0]  amount,
    input  logic [DATA_W-1:0] operand,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] sh_in,
    output logic [1:0]        sh_set,
    input  logic [DATA_W-1:0] sh_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0]       SET_PASS = 2'b00;
    localparam logic [1:0]       SET_SRA1 = 2'b10;
    localparam logic [1:0]       SET_SLL8 = 2'b01;
    localparam logic             OP_SRA   = 1'b0;
    localparam logic [AMT_W-1:0] CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [AMT_W-1:0]  cnt_q, cnt_d;
    logic              op_q, op_d;
    logic              accept;
    logic              early_stop;

    // SLL8 only honours the two low amount bits; more than three byte shifts is meaningless.
    function automatic logic [AMT_W-1:0] load_count(input logic o, input logic [AMT_W-1:0] a);
        logic [AMT_W-1:0] c;
        c = a;
        if (o != OP_SRA) begin
            c = {{(AMT_W-2){1'b0}}, a[1:0]};
        end
        return c;
    endfunction

`ifdef SHIFT_SEQ_EARLY_EN
    // Further SRA steps cannot change an all-zeros or all-ones accumulator.
    assign early_stop = (op_q == OP_SRA) && ((acc_q == '0) || (acc_q == '1));
`else
    assign early_stop = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        sh_set   = SET_PASS;
        accept   = start && (state_q != ST_RUN);

        case (state_q)
            ST_RUN: begin
                if (early_stop) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    sh_set = (op_q == OP_SRA) ? SET_SRA1 : SET_SLL8;
                    acc_d  = sh_out;
                    cnt_d  = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = state_q;
        endcase

        if (accept) begin
            acc_d   = operand;
            op_d    = op;
            cnt_d   = load_count(op, amount);
            state_d = (cnt_d == '0) ? ST_DONE : ST_RUN;
        end

        // Result is captured on the way into DONE so it survives a back-to-back accept.
        if (state_d == ST_DONE) begin
            result_d = acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign sh_in  = acc_q;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift controller for the Mic-1 datapath shifter. It turns a single request (operand, operation, amount) into a sequence of single-step shifter operations: arithmetic right by 1 (`SET=10`) or left by 8 (`SET=01`). Each step's shifter output is recirculated into an internal accumulator. The block drives the shifter's `ALU_out`/`SET` inputs and reads back its `Shift` output. It sits between the microcontroller's sequencing logic and the shifter.

## Interface
Parameters:
- DATA_W, 32, datapath width; fixed to the shifter width.
- AMT_W, 5, width of the shift-amount field.

Ports:
- clk  in  1  rising-edge clock, the single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe, sampled every cycle.
- op  in  1  0 = SRA by `amount`; 1 = SLL8 by `amount[1:0]` (`amount[4:2]` ignored).
- amount  in  AMT_W  step count.
- operand  in  DATA_W  value to shift; captured on accept.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; `result` is valid in that cycle.
- result  out  DATA_W  final value; holds until the next accept.
- sh_in  out  DATA_W  drives the shifter's `ALU_out`; always equals the accumulator.
- sh_set  out  2  drives the shifter's `SET`.
- sh_out  in  DATA_W  the shifter's `Shift` output, which is combinational from `sh_in`/`sh_set`.

## Operation
- States: IDLE, RUN, DONE.
- Reset: state=IDLE; acc=0, cnt=0, busy=0, done=0, result=0, sh_in=0, sh_set=00.
- Accept: `start=1` while in IDLE or DONE. On accept:
  - acc ← operand.
  - cnt ← amount (SRA) or amount[1:0] (SLL8).
  - op is latched.
  - Next state is RUN if cnt≠0; otherwise DONE.
- Ignored requests: `start` while in RUN is ignored, with no queueing.
- RUN, each cycle:
  - sh_set = 10 for SRA, 01 for SLL8.
  - acc ← sh_out; cnt ← cnt−1.
  - When the decremented cnt reaches 0, next state is DONE.
- DONE (one cycle):
  - done=1 and result=acc, written at DONE entry.
  - Without an accept, next state is IDLE.
- Outside RUN: sh_set=00 (pass-through); shifter output is ignored.
- SRA semantics: the sign bit replicates. 31 steps of 0x80000000 gives 0xFFFFFFFF.
- SLL8 semantics: zeros fill from the right. Three steps leaves only bits [7:0] in [31:24].
- Reset mid-operation: returns to IDLE on the next edge. The accumulator and result clear, and no done pulse is issued.

## Timing
- Accept is sampled at the end of cycle T.
- Latency: done=1 in cycle T+1+cnt (T+1 when cnt=0).
- busy=1 in cycles T+1 … T+cnt.
- Back-to-back: an accept in the DONE cycle starts the next operation with no idle gap.
- Throughput: one step per cycle; the shifter path is single-cycle combinational.

## Configuration
- Macro: `SHIFT_SEQ_EARLY_EN`.
- Defined:
  - In RUN with op=SRA, if acc is 0x00000000 or 0xFFFFFFFF at the start of the cycle, no step is applied.
  - Next state is DONE and the remaining count is discarded.
  - Results are identical to the undefined build; latency may be shorter.
- Undefined: every request takes exactly cnt RUN cycles.

## Test plan
- Reset: assert rst for 2 cycles.
  - All outputs read 0 and sh_set=00.
  - Pulsing rst in RUN returns to IDLE, busy=0, and no done pulse.
- SRA:
  - Stimulus: operand=0x80000000, op=0, amount=4, accepted at T.
  - sh_set=10 in T+1..T+4.
  - done at T+5 with result=0xF8000000.
- SLL8:
  - Stimulus: operand=0x000000AB, op=1, amount=2.
  - done at T+3 with result=0x00AB0000.
  - amount=6 gives the identical result and timing.
- Zero amount:
  - Stimulus: operand=0x12345678, amount=0.
  - done at T+1 with result=0x12345678; busy never asserts.
- Protocol:
  - `start` asserted during RUN with a different operand has no effect on result or timing.
  - An accept in the DONE cycle yields the second done at DONE+1+cnt.
- Early termination:
  - Stimulus: operand=0xFFFF0000, op=0, amount=31.
  - Without the macro: done at T+32, result=0xFFFFFFFF.
  - With `SHIFT_SEQ_EARLY_EN`: done at T+18, result=0xFFFFFFFF.
